// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the round-robin APB master:
//   - apb_state_e : bus-sequencer state encoding (00 is illegal and recovers
//                   to IDLE)
//   - APB_DEFAULT_WIDTH : default address/data bus width
//   - idx_width() : bit width needed to hold a requester index
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b01,
        ST_SETUP  = 2'b10,
        ST_ACCESS = 2'b11
    } apb_state_e;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Purely combinational round-robin arbiter. When enabled, it picks the first
// asserted request searching upward from (last_grant_i + 1) mod NUM_REQ with
// wrap-around.
// Ports:
//   req_i        : request vector, one bit per client
//   last_grant_i : index of the most recently granted client
//   enable_i     : grant opportunity this cycle
//   grant_o      : one-hot grant (all zero when disabled or no request)
//   grant_idx_o  : binary index of the granted client (0 when no grant)
// ---------------------------------------------------------------------------
import apb_pkg::*;

module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDXW-1:0]    grant_idx_o
);

    logic [IDXW-1:0] cand;
    logic            found;

    // Walk the clients in priority order starting just after the last
    // winner; the first requester met wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        cand        = '0;
        found       = 1'b0;
        if (enable_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IDXW'((int'(last_grant_i) + 1 + k) % NUM_REQ);
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    grant_o[cand] = 1'b1;
                    grant_idx_o = cand;
                end
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
// Multi-requester APB master. NUM_REQ clients share one APB bus through
// round-robin arbitration; the winner's command is captured, sequenced
// through SETUP/ACCESS, and the result is returned to the owning client as a
// one-cycle registered response pulse.
// Ports:
//   pclk, preset             : clock, asynchronous active-high reset
//   req_valid/write/addr/wdata : per-client command (slice i at [i*WIDTH +: WIDTH])
//   req_ready                : one-hot combinational grant (command taken at this edge)
//   rsp_valid/rdata/err      : registered completion pulse, data and error
//   pready, prdata, pslverr  : APB slave response
//   psel, penable, pwrite, paddr, pwdata : APB master outputs
// A transfer that waits TIMEOUT ACCESS cycles without pready is aborted with
// an error response; TIMEOUT = 0 disables the abort.
// ---------------------------------------------------------------------------
import apb_pkg::*;

module apb_rr_master #(
    parameter int WIDTH   = APB_DEFAULT_WIDTH,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     rsp_err,
    input  logic                     pready,
    input  logic [WIDTH-1:0]         prdata,
    input  logic                     pslverr,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [WIDTH-1:0]         paddr,
    output logic [WIDTH-1:0]         pwdata
);

    localparam int IDXW = idx_width(NUM_REQ);
    localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apb_state_e          state_q;
    logic [IDXW-1:0]     last_grant_q;
    logic [IDXW-1:0]     owner_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    paddr_q;
    logic [WIDTH-1:0]    pwdata_q;
    logic                pwrite_q;
    logic                psel_q;
    logic                penable_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [WIDTH-1:0]    rsp_rdata_q;
    logic                rsp_err_q;

    logic [NUM_REQ-1:0]  rsp_valid_d;
    logic [WIDTH-1:0]    rsp_rdata_d;
    logic                rsp_err_d;

    logic                timeout_hit;
    logic                xfer_done;
    logic                arb_en;
    logic                load_cmd;
    logic [NUM_REQ-1:0]  grant;
    logic [IDXW-1:0]     grant_idx;
    logic [WIDTH-1:0]    win_addr;
    logic [WIDTH-1:0]    win_wdata;
    logic                win_write;

    // Completion happens on pready, or when the wait counter has reached its
    // last allowed value with the slave still stalling. Either one is also a
    // grant opportunity, which is what makes back-to-back transfers possible.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready &&
                      (cnt_q == TO_LAST);
        xfer_done   = (state_q == ST_ACCESS) && (pready || timeout_hit);
        arb_en      = (state_q == ST_IDLE) || xfer_done;
        load_cmd    = |grant;
    end

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (arb_en),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // Select the winner's command slice with a one-hot mux.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr  = req_addr[i*WIDTH +: WIDTH];
                win_wdata = req_wdata[i*WIDTH +: WIDTH];
                win_write = req_write[i];
            end
        end
    end

    // Response for the cycle after completion. A timeout forces an error with
    // zero data; writes always return zero data.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (xfer_done) begin
            rsp_valid_d = NUM_REQ'(1) << owner_q;
            rsp_err_d   = timeout_hit || pslverr;
            if (!timeout_hit && !pwrite_q) begin
                rsp_rdata_d = prdata;
            end
        end
    end

    // Bus sequencer with registered APB outputs. Capturing the command is
    // done outside the case because it happens identically from IDLE and
    // from a completing ACCESS.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;

            if (load_cmd) begin
                paddr_q      <= win_addr;
                pwdata_q     <= win_wdata;
                pwrite_q     <= win_write;
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
            end

            case (state_q)
                ST_IDLE: begin
                    if (load_cmd) begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    psel_q    <= 1'b1;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        penable_q <= 1'b0;
                        if (load_cmd) begin
                            state_q <= ST_SETUP;
                            psel_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            psel_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    pwrite_q  <= 1'b0;
                    paddr_q   <= '0;
                    pwdata_q  <= '0;
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule
